// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types, constants and the arbitration pick for mem_bus_arbiter.
// Optional build macro: ARB_FIXED_PRIO_EN selects fixed m0-first priority
// instead of the default round-robin.
package mem_bus_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Master indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Wait counter width; covers RD_LAT-1 for RD_LAT up to 7
    localparam int LAT_W = 3;

    // Pick the master to grant. Only meaningful when at least one request is high.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic last_grant);
`ifdef ARB_FIXED_PRIO_EN
        // m0 always wins; last_grant is tracked by the caller but plays no role here
        return req0 ? M0 : M1;
`else
        // On a tie, hand the bus to whichever master did not have it last
        if (req0 && req1) begin
            return (last_grant == M0) ? M1 : M0;
        end
        return req0 ? M0 : M1;
`endif
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters (CPU, VGA fetch), the arbiter and the
// single-port data RAM. The slave modport is the arbiter's view; the master
// modport is the view of the requesters plus RAM around it.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 32
);
    // CPU load/store port
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;

    // VGA fetch port (read-only)
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;

    // RAM port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_ack,
        input  m1_req, m1_addr,
        output m1_rdata, m1_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack,
        output m1_req, m1_addr,
        input  m1_rdata, m1_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-port data RAM. Each access runs
// IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> DONE, so reads and writes share
// identical ack timing. All outputs are registered.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed m0 priority instead of round-robin).
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW     = 11,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_arbiter_if.slave  bus,
    output logic              busy
);

    // Registered state
    state_t             r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic [LAT_W-1:0]   r_cnt;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic [DW-1:0]      r_m0_rdata;
    logic [DW-1:0]      r_m1_rdata;
    logic               r_m0_ack;
    logic               r_m1_ack;
    logic               r_busy;

    // Next-state values
    state_t             w_state_nxt;
    logic               w_grant_nxt;
    logic               w_last_grant_nxt;
    logic [LAT_W-1:0]   w_cnt_nxt;
    logic               w_mem_en_nxt;
    logic               w_mem_we_nxt;
    logic [AW-1:0]      w_mem_addr_nxt;
    logic [DW-1:0]      w_mem_wdata_nxt;
    logic [DW-1:0]      w_m0_rdata_nxt;
    logic [DW-1:0]      w_m1_rdata_nxt;
    logic               w_m0_ack_nxt;
    logic               w_m1_ack_nxt;
    logic               w_pick;

    // Next state and next registered outputs; everything holds or idles by default
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;
        w_m0_ack_nxt     = 1'b0;
        w_m1_ack_nxt     = 1'b0;
        w_pick           = arb_pick(bus.m0_req, bus.m1_req, r_last_grant);

        unique case (r_state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // Latch the winner's command straight into the RAM-side registers
                    w_grant_nxt  = w_pick;
                    w_state_nxt  = ISSUE;
                    w_mem_en_nxt = 1'b1;
                    if (w_pick == M0) begin
                        w_mem_we_nxt    = bus.m0_we;
                        w_mem_addr_nxt  = bus.m0_addr;
                        w_mem_wdata_nxt = bus.m0_wdata;
                    end else begin
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = bus.m1_addr;
                        w_mem_wdata_nxt = '0;
                    end
                end
            end
            ISSUE: begin
                w_cnt_nxt   = LAT_W'(RD_LAT - 1);
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    // This cycle is exactly RD_LAT after ISSUE: RAM data is valid now
                    w_state_nxt = DONE;
                    if (r_grant == M0) begin
                        w_m0_rdata_nxt = bus.mem_rdata;
                        w_m0_ack_nxt   = 1'b1;
                    end else begin
                        w_m1_rdata_nxt = bus.mem_rdata;
                        w_m1_ack_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                w_last_grant_nxt = r_grant;
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= M0;
            r_last_grant <= M1;
            r_cnt        <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
            r_m0_ack     <= w_m0_ack_nxt;
            r_m1_ack     <= w_m1_ack_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.m0_rdata  = r_m0_rdata;
    assign bus.m0_ack    = r_m0_ack;
    assign bus.m1_rdata  = r_m1_rdata;
    assign bus.m1_ack    = r_m1_ack;
    assign busy          = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: an RD_LAT=1 instance with a RAM
// model and ack scoreboard, plus an RD_LAT=3 instance with a driven RAM data bus.
module tb_mem_bus_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic busy1;
    logic busy3;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) if1 ();
    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) if3 ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1)
    );
    mem_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3), .busy(busy3)
    );

    // Single-port RAM model with one cycle read latency, preloaded on first clock
    logic [31:0] ram [0:2047];
    logic [31:0] ram_q = '0;
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 2048; i++)
                ram[i] <= (i == 'h010) ? 32'h0000_00AB : (32'hA500_0000 | 32'(i));
            ram_init <= 1'b1;
        end else if (if1.mem_en) begin
            if (if1.mem_we) ram[if1.mem_addr] <= if1.mem_wdata;
            ram_q <= ram[if1.mem_addr];
        end
    end
    assign if1.mem_rdata = ram_q;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Scoreboard of expected acks on the RD_LAT=1 instance
    typedef struct {
        logic        m;
        logic        chk_data;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    function automatic void sb_push(logic m, logic we, logic [31:0] d);
        sb_t e;
        e.m = m; e.chk_data = ~we; e.data = d;
        sb_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (if1.m0_ack || if1.m1_ack)) begin
            sb_t e;
            chk("sb_ack_both", {31'b0, if1.m0_ack & if1.m1_ack}, 32'd0);
            chk("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_master", {31'b0, if1.m1_ack}, {31'b0, e.m});
                if (e.chk_data)
                    chk("sb_rdata", e.m ? if1.m1_rdata : if1.m0_rdata, e.data);
            end
        end
    end

    typedef struct {
        logic        m;
        logic        we;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    // One isolated access on the RD_LAT=1 instance, checked for timing and data
    task automatic do_txn(input vec_t v);
        int s, en_c, ack_c, other;
        logic [31:0] got;
        @(posedge clk); #1;
        s = cyc;
        if (v.m == 1'b0) begin
            if1.m0_req = 1'b1; if1.m0_we = v.we; if1.m0_addr = v.addr; if1.m0_wdata = v.wdata;
        end else begin
            if1.m1_req = 1'b1; if1.m1_addr = v.addr;
        end
        sb_push(v.m, v.we, v.exp);
        en_c = -1; ack_c = -1; other = 0; got = '0;
        for (int t = 0; t < 20 && ack_c < 0; t++) begin
            @(negedge clk);
            if (if1.mem_en && en_c < 0) begin
                en_c = cyc;
                chk("issue_addr", {21'b0, if1.mem_addr}, {21'b0, v.addr});
                chk("issue_we", {31'b0, if1.mem_we}, {31'b0, v.we});
                if (v.we) chk("issue_wdata", if1.mem_wdata, v.wdata);
            end
            if ((v.m ? if1.m1_ack : if1.m0_ack)) begin
                ack_c = cyc;
                got = v.m ? if1.m1_rdata : if1.m0_rdata;
            end
            if ((v.m ? if1.m0_ack : if1.m1_ack)) other++;
        end
        chk("ack_latency", ack_c - s, 32'd3);
        chk("en_latency", en_c - s, 32'd1);
        chk("other_ack", other, 32'd0);
        if (!v.we) chk("txn_rdata", got, v.exp);
        @(posedge clk); #1;
        if1.m0_req = 1'b0; if1.m1_req = 1'b0;
    endtask

    // Both masters hold req until each has n acks, dropping it the cycle after its last
    task automatic hold_reqs(input int n);
        int c0, c1;
        c0 = 0; c1 = 0;
        @(posedge clk); #1;
        if1.m0_req = 1'b1; if1.m0_we = 1'b0; if1.m0_addr = 11'h020;
        if1.m1_req = 1'b1; if1.m1_addr = 11'h021;
        for (int t = 0; t < 200 && (c0 < n || c1 < n); t++) begin
            @(negedge clk);
            if (if1.m0_ack) c0++;
            if (if1.m1_ack) c1++;
            @(posedge clk); #1;
            if (c0 >= n) if1.m0_req = 1'b0;
            if (c1 >= n) if1.m1_req = 1'b0;
        end
        chk("hold_m0_acks", c0, n);
        chk("hold_m1_acks", c1, n);
        if1.m0_req = 1'b0; if1.m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, a1, a2, nwe, wec, nack, ackc, en_c, ack_c;
        logic [31:0] got;
        logic        busy4;

        tbl[0] = '{1'b0, 1'b0, 11'h010, 32'h0,         32'h0000_00AB};
        tbl[1] = '{1'b0, 1'b1, 11'h005, 32'hDEAD_BEEF, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 11'h005, 32'h0,         32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 1'b0, 11'h005, 32'h0,         32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 1'b0, 11'h7FF, 32'h0,         32'hA500_07FF};
        tbl[5] = '{1'b0, 1'b1, 11'h7FF, 32'h1234_5678, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 11'h7FF, 32'h0,         32'h1234_5678};
        tbl[7] = '{1'b0, 1'b0, 11'h000, 32'h0,         32'hA500_0000};

        rst_n = 1'b0;
        if1.m0_req = 1'b0; if1.m0_we = 1'b0; if1.m0_addr = '0; if1.m0_wdata = '0;
        if1.m1_req = 1'b0; if1.m1_addr = '0;
        if3.m0_req = 1'b0; if3.m0_we = 1'b0; if3.m0_addr = '0; if3.m0_wdata = '0;
        if3.m1_req = 1'b0; if3.m1_addr = '0; if3.mem_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", {31'b0, if1.mem_en}, 32'd0);
        chk("rst_mem_addr", {21'b0, if1.mem_addr}, 32'd0);
        chk("rst_acks", {30'b0, if1.m0_ack, if1.m1_ack}, 32'd0);
        chk("rst_rdata", if1.m0_rdata | if1.m1_rdata, 32'd0);
        chk("rst_busy", {30'b0, busy1, busy3}, 32'd0);
        rst_n = 1'b1;

        // Tie from reset release: round-robin alternates, fixed priority serves m0 first
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) sb_push(1'b0, 1'b0, 32'hA500_0020);
        for (int i = 0; i < 4; i++) sb_push(1'b1, 1'b0, 32'hA500_0021);
`else
        for (int i = 0; i < 4; i++) begin
            sb_push(1'b0, 1'b0, 32'hA500_0020);
            sb_push(1'b1, 1'b0, 32'hA500_0021);
        end
`endif
        hold_reqs(4);

        for (int i = 0; i < 8; i++) do_txn(tbl[i]);

        // Back-to-back write then read with req held across the ack
        @(posedge clk); #1;
        s = cyc;
        if1.m0_req = 1'b1; if1.m0_we = 1'b1; if1.m0_addr = 11'h006; if1.m0_wdata = 32'h0BAD_F00D;
        sb_push(1'b0, 1'b1, 32'h0);
        sb_push(1'b0, 1'b0, 32'h0BAD_F00D);
        a1 = -1; a2 = -1; nwe = 0; wec = -1; got = '0;
        for (int t = 0; t < 30 && a2 < 0; t++) begin
            @(negedge clk);
            if (if1.mem_en && if1.mem_we) begin nwe++; wec = cyc; end
            if (if1.m0_ack) begin
                if (a1 < 0) a1 = cyc;
                else begin a2 = cyc; got = if1.m0_rdata; end
            end
            @(posedge clk); #1;
            if (a1 >= 0 && cyc == a1 + 1) if1.m0_we = 1'b0;
        end
        if1.m0_req = 1'b0;
        chk("b2b_we_count", nwe, 32'd1);
        chk("b2b_we_cycle", wec - s, 32'd1);
        chk("b2b_first_ack", a1 - s, 32'd3);
        chk("b2b_spacing", a2 - a1, 32'd4);
        chk("b2b_rdata", got, 32'h0BAD_F00D);

        // Reset during WAIT of a write: outputs clear at once, no ack, write already in RAM
        @(posedge clk); #1;
        if1.m0_req = 1'b1; if1.m0_we = 1'b1; if1.m0_addr = 11'h033; if1.m0_wdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_busy", {31'b0, busy1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_en_we", {30'b0, if1.mem_en, if1.mem_we}, 32'd0);
        chk("arst_mem_addr", {21'b0, if1.mem_addr}, 32'd0);
        chk("arst_mem_wdata", if1.mem_wdata, 32'd0);
        chk("arst_m0_rdata", if1.m0_rdata, 32'd0);
        chk("arst_m1_rdata", if1.m1_rdata, 32'd0);
        chk("arst_busy", {31'b0, busy1}, 32'd0);
        if1.m0_req = 1'b0; if1.m0_we = 1'b0;
        nack = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (if1.m0_ack || if1.m1_ack) nack++;
        end
        chk("arst_no_ack", nack, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn('{1'b1, 1'b0, 11'h033, 32'h0, 32'hCAFE_F00D});
        sb_push(1'b0, 1'b0, 32'hA500_0020);
        sb_push(1'b1, 1'b0, 32'hA500_0021);
        hold_reqs(1);

        // m1 drops req during WAIT: the access still completes with one ack
        @(posedge clk); #1;
        s = cyc;
        if1.m1_req = 1'b1; if1.m1_addr = 11'h021;
        sb_push(1'b1, 1'b0, 32'hA500_0021);
        repeat (2) @(posedge clk);
        #1;
        if1.m1_req = 1'b0;
        nack = 0; ackc = -1; busy4 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (if1.m1_ack) begin nack++; ackc = cyc; end
            if (cyc == s + 4) busy4 = busy1;
        end
        chk("drop_ack_count", nack, 32'd1);
        chk("drop_ack_cycle", ackc - s, 32'd3);
        chk("drop_busy_idle", {31'b0, busy4}, 32'd0);

        // RD_LAT=3: data bus changes every cycle; only the value 3 cycles after ISSUE is taken
        @(posedge clk); #1;
        s = cyc;
        if3.m1_req = 1'b1; if3.m1_addr = 11'h400; if3.mem_rdata = 32'h1000_0000;
        en_c = -1; ack_c = -1; got = '0; nack = 0;
        for (int t = 0; t < 20 && ack_c < 0; t++) begin
            @(negedge clk);
            if (if3.mem_en && en_c < 0) begin
                en_c = cyc;
                chk("lat3_addr", {21'b0, if3.mem_addr}, 32'h400);
            end
            if (if3.m0_ack) nack++;
            if (if3.m1_ack) begin ack_c = cyc; got = if3.m1_rdata; end
            else begin
                @(posedge clk); #1;
                if3.mem_rdata = 32'h1000_0000 + 32'(cyc - s);
            end
        end
        @(posedge clk); #1;
        if3.m1_req = 1'b0;
        chk("lat3_en_cycle", en_c - s, 32'd1);
        chk("lat3_ack_cycle", ack_c - s, 32'd5);
        chk("lat3_rdata", got, 32'h1000_0004);
        chk("lat3_no_m0_ack", nack, 32'd0);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
